// File: rtl/rng_debias_packer.sv
// Conditions a raw entropy bit stream: optional von Neumann debiasing, MSB-first
// byte packing, a small FWFT byte FIFO and a repetition-count health test.
module rng_debias_packer #(
  parameter int FIFO_DEPTH = 4,
  parameter int REP_LIMIT  = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          raw_bit,
  input  logic                          raw_valid,
  input  logic                          bypass,
  output logic [7:0]                    out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          health_fail
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int RW = $clog2(REP_LIMIT) + 1;
  localparam logic [RW-1:0] RUN_ONE = RW'(1);
  localparam logic [RW-1:0] RUN_MAX = RW'(REP_LIMIT);
  localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

  logic          bypass_q, bypass_d;
  logic          hold_vld_q, hold_vld_d;
  logic          hold_bit_q, hold_bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [2:0]    bcnt_q, bcnt_d;
  logic [RW-1:0] run_q, run_d;
  logic          last_q, last_d;
  logic          hf_q, hf_d;
  logic          ovf_q, ovf_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [LW-1:0] lvl_q, lvl_d;
  logic [7:0]    mem_q [FIFO_DEPTH];

  logic          hold_eff;
  logic          trip;
  logic          emit_vld;
  logic          emit_bit;
  logic          push_req;
  logic          push_ok;
  logic          pop;
  logic          full;
  logic [7:0]    push_byte;

  always_comb begin
    bypass_d   = bypass;
    hold_vld_d = hold_vld_q;
    hold_bit_d = hold_bit_q;
    shreg_d    = shreg_q;
    bcnt_d     = bcnt_q;
    run_d      = run_q;
    last_d     = last_q;
    hf_d       = hf_q;
    ovf_d      = ovf_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    lvl_d      = lvl_q;
    trip       = 1'b0;
    emit_vld   = 1'b0;
    emit_bit   = 1'b0;
    push_req   = 1'b0;
    push_ok    = 1'b0;

    // Repetition test on the raw stream, independent of debiasing.
    if (raw_valid) begin
      if ((run_q != '0) && (raw_bit == last_q)) begin
        run_d = (run_q == RUN_MAX) ? run_q : run_q + RUN_ONE;
      end else begin
        run_d = RUN_ONE;
      end
      last_d = raw_bit;
      trip   = (run_d == RUN_MAX);
    end
    hf_d = hf_q | trip;

    // A mode switch invalidates a half-collected pair.
    hold_eff   = hold_vld_q && (bypass == bypass_q);
    hold_vld_d = hold_eff;

    if (raw_valid && !hf_q && !trip) begin
      if (bypass) begin
        emit_vld = 1'b1;
        emit_bit = raw_bit;
      end else if (!hold_eff) begin
        hold_vld_d = 1'b1;
        hold_bit_d = raw_bit;
      end else begin
        hold_vld_d = 1'b0;
        emit_vld   = (hold_bit_q != raw_bit);
        emit_bit   = hold_bit_q;
      end
    end

    push_byte = {shreg_q[6:0], emit_bit};
    if (emit_vld) begin
      shreg_d  = push_byte;
      bcnt_d   = bcnt_q + 3'd1;
      push_req = (bcnt_q == 3'd7);
    end

    pop  = (lvl_q != '0) && out_ready;
    full = (lvl_q == LVL_FULL);
    // A pop frees the slot in the same cycle, so a full FIFO can still accept.
    push_ok = push_req && (!full || pop);
    ovf_d   = ovf_q | (push_req && full && !pop);

    if (push_ok) wr_d = wr_q + PW'(1);
    if (pop)     rd_d = rd_q + PW'(1);
    lvl_d = lvl_q + LW'(push_ok) - LW'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bypass_q   <= 1'b0;
      hold_vld_q <= 1'b0;
      hold_bit_q <= 1'b0;
      shreg_q    <= '0;
      bcnt_q     <= '0;
      run_q      <= '0;
      last_q     <= 1'b0;
      hf_q       <= 1'b0;
      ovf_q      <= 1'b0;
      wr_q       <= '0;
      rd_q       <= '0;
      lvl_q      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      bypass_q   <= bypass_d;
      hold_vld_q <= hold_vld_d;
      hold_bit_q <= hold_bit_d;
      shreg_q    <= shreg_d;
      bcnt_q     <= bcnt_d;
      run_q      <= run_d;
      last_q     <= last_d;
      hf_q       <= hf_d;
      ovf_q      <= ovf_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      lvl_q      <= lvl_d;
      if (push_ok) mem_q[wr_q] <= push_byte;
    end
  end

  assign out_data    = mem_q[rd_q];
  assign out_valid   = (lvl_q != '0);
  assign fifo_level  = lvl_q;
  assign overflow    = ovf_q;
  assign health_fail = hf_q;

endmodule

// File: doc/rng_debias_packer.md
# rng_debias_packer

Downstream conditioning stage for the RNG tile's raw entropy source. Accepts one raw random bit per valid cycle, optionally applies von Neumann debiasing, packs the surviving bits into bytes and buffers them in a small first-word-fall-through FIFO with a ready/valid output. A repetition-count health test runs on the raw stream and halts byte production on failure.

## Interface

- FIFO_DEPTH, 4, byte FIFO entries; power of two, at least 2.
- REP_LIMIT, 32, raw run length that trips the health test; at least 2.

- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- raw_bit  in  1  raw entropy bit.
- raw_valid  in  1  raw_bit is valid this cycle; no backpressure, one bit per cycle.
- bypass  in  1  1 = skip von Neumann and pack every raw bit.
- out_data  out  8  FIFO head byte.
- out_valid  out  1  out_data holds a valid byte.
- out_ready  in  1  consumer accepts the byte when out_valid && out_ready.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  number of bytes stored.
- overflow  out  1  sticky: a completed byte was dropped because the FIFO was full.
- health_fail  out  1  sticky: the repetition test tripped.

## Operation

- Reset: out_data=0x00, out_valid=0, fifo_level=0, overflow=0, health_fail=0, pair holder empty, shift register and bit count cleared, run counter 0.
- Debiaser (bypass=0): the first valid bit is held. On the second valid bit the pair is evaluated: 10 emits 1, 01 emits 0, 00 and 11 emit nothing. The holder is then emptied. The decision is made on the second bit's cycle.
- Bypass (bypass=1): each valid raw bit is emitted in the same cycle.
- A change of bypass between consecutive cycles empties the pair holder. The partial byte is kept.
- Packer: shreg <= {shreg[6:0], bit}, so the first bit ends up at bit 7 (MSB-first). On the 8th emitted bit the completed byte is pushed to the FIFO and the bit count returns to 0.
- FIFO push/pop:
  - Push when full without a pop in the same cycle: the byte is discarded and overflow is set. The byte FIFO contents are unchanged.
  - Push and pop in the same cycle while full: both take effect; fifo_level is unchanged and overflow stays 0.
  - Pop when empty is ignored.
- Health test:
  - Run counter tracks consecutive identical raw bits among valid cycles. The first valid bit sets the count to 1. A repeat increments it, saturating. A differing bit resets it to 1.
  - When the count reaches REP_LIMIT, health_fail is set.
  - While health_fail=1: no new bits are emitted and no pushes occur. The FIFO still drains normally.
  - health_fail and overflow clear only on rst.
- Widths: the run counter is $clog2(REP_LIMIT)+1 bits. FIFO pointers are $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.

## Timing

- A byte completing in cycle N is pushed at edge N. If the FIFO was empty, out_valid=1 with that byte from cycle N+1. Latency is one clock from the 8th emitted bit.
- out_data and out_valid come from registers (FIFO head). out_data is stable while out_valid && !out_ready.
- On a pop at edge M, the next byte (if any) is presented from cycle M+1. Back-to-back pops sustain one byte per cycle.
- fifo_level updates at the same edge as the push or pop.
- health_fail rises at the edge that samples the REP_LIMIT-th identical bit, and is visible in the next cycle. If a byte would complete on that same bit, the byte is not pushed.
- overflow rises at the edge of the dropped push.
- rst asserted at any time, including mid-byte, mid-pair or with the FIFO partly full:
  - Immediately returns every output to its reset value.
  - Discards the held bit, the partial byte and all FIFO contents.
  - After deassertion, the first valid bit starts a fresh pair, byte and run.

## Test plan

- Bypass pack: bypass=1, out_ready=1, raw bits 1,0,1,0,0,1,0,1 on consecutive cycles -> out_data=0xA5, out_valid=1 for exactly one cycle, starting the cycle after the 8th bit; fifo_level returns to 0.
- Von Neumann: bypass=0, raw pairs 10,01,11,10,00,01,10,10,01,10 -> emitted bits 1,0,1,0,1,1,0,1 -> out_data=0xAD; pairs 11 and 00 produce nothing.
- Overflow and order: out_ready=0, bypass=1, five bytes 0x01..0x05 -> fifo_level=4, overflow=1. Raise out_ready -> 0x01,0x02,0x03,0x04 on consecutive cycles, then out_valid=0.
- Full push/pop: FIFO holding 4 bytes, out_ready=1 held during the cycle a 5th byte completes -> fifo_level stays 4, overflow=0, the 5th byte is delivered last.
- Health: 32 consecutive valid raw 1s (REP_LIMIT=32), bypass=1 -> health_fail=1 in the cycle after bit 32. The 4 bytes 0xFF completed (3 before trip; 4th completes on the tripping bit, so it is not pushed) -> exactly 3 bytes of 0xFF delivered, no further bytes; 31 ones then a 0 -> health_fail stays 0.
- Reset mid-operation: 5 bits into a byte with 2 bytes queued, pulse rst asynchronously (not aligned to clk) -> all outputs 0 immediately. The next 8 bypassed bits 0x3C yield out_data=0x3C as the only byte.
